// File: rtl/isa_types.sv
// Shared ISA-level types for the hart: XLEN, decoded opcodes and sequencer state encoding.
package isa_types;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [3:0] {
    OPCODE_UNKNOWN,
    OPCODE_LUI,
    OPCODE_AUIPC,
    OPCODE_JAL,
    OPCODE_JALR,
    OPCODE_BRANCH,
    OPCODE_LOAD,
    OPCODE_STORE,
    OPCODE_OP_IMM,
    OPCODE_OP,
    OPCODE_SYSTEM
  } opcode_t;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StHalt
  } hart_state_t;

  // Loads are recognised by opcode; stores by the compute stage's request.
  function automatic logic needs_mem(input opcode_t op, input logic store_en);
    return (op == OPCODE_LOAD) || store_en;
  endfunction

endpackage

// File: rtl/hart_sequencer.sv
// Multi-cycle hart control: fetch/decode/execute/mem/writeback sequencing, PC and instret.
module hart_sequencer
  import isa_types::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  opcode_t         opcode,
  input  logic            rd_out_enable,
  input  logic            store_enable,
  input  logic            jump_enable,
  input  logic [XLEN-1:0] jump_target_addr,
  input  logic [XLEN-1:0] eff_addr,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic            instr_latch_en,
  output logic            load_latch_en,
  output logic            rd_write_en,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret,
  output logic            halted
);

  hart_state_t state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc      <= RESET_PC;
      instret <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          state_q <= (opcode == OPCODE_UNKNOWN) ? StHalt : StExecute;
        end
        StExecute: begin
          state_q <= needs_mem(opcode, store_enable) ? StMem : StWriteback;
        end
        StMem: begin
          if (mem_ready) state_q <= StWriteback;
        end
        StWriteback: begin
          pc      <= jump_enable ? jump_target_addr : pc + XLEN'(4);
          instret <= instret + XLEN'(1);
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StHalt;
        end
      endcase
    end
  end

  // Strobes are masked while reset is high so an abandoned transaction never completes.
  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = pc;
    instr_latch_en = 1'b0;
    load_latch_en  = 1'b0;
    rd_write_en    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_req        = 1'b1;
          instr_latch_en = mem_ready;
        end
        StMem: begin
          mem_req       = 1'b1;
          mem_we        = store_enable;
          mem_addr      = eff_addr;
          load_latch_en = mem_ready && (opcode == OPCODE_LOAD);
        end
        StWriteback: begin
          rd_write_en = rd_out_enable;
        end
        default: begin
        end
      endcase
    end
  end

  assign halted = (state_q == StHalt);

endmodule

// File: doc/hart_sequencer.md
HART_SEQUENCER -- requirements
Module: hart_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  opcode_t  decoded opcode of the latched instruction.
REQ-005 SHALL have port rd_out_enable  input  1  compute stage requests a register write.
REQ-006 SHALL have port store_enable  input  1  compute stage requests a store.
REQ-007 SHALL have port jump_enable  input  1  compute stage requests a PC redirect.
REQ-008 SHALL have port jump_target_addr  input  XLEN  redirect target.
REQ-009 SHALL have port eff_addr  input  XLEN  load/store effective address.
REQ-010 SHALL have port mem_ready  input  1  memory completes the current request.
REQ-011 SHALL have port mem_req  output  1  memory request valid.
REQ-012 SHALL have port mem_we  output  1  request is a write.
REQ-013 SHALL have port mem_addr  output  XLEN  request address.
REQ-014 SHALL have port instr_latch_en  output  1  capture fetched word into instruction register.
REQ-015 SHALL have port load_latch_en  output  1  capture load data into load_val register.
REQ-016 SHALL have port rd_write_en  output  1  one-cycle register-file write strobe.
REQ-017 SHALL have port pc  output  XLEN  architectural PC, owned by this block.
REQ-018 SHALL have port instret  output  XLEN  retired-instruction counter.
REQ-019 SHALL have port halted  output  1  trap state reached.

Function
REQ-020 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-021 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, hold them until mem_ready, then pulse instr_latch_en in the mem_ready cycle and go to DECODE.
REQ-022 DECODE SHALL last one cycle; opcode OPCODE_UNKNOWN -> HALT, else -> EXECUTE.
REQ-023 EXECUTE SHALL last one cycle; OPCODE_LOAD or store_enable -> MEM, else -> WRITEBACK.
REQ-024 MEM SHALL drive mem_req=1, mem_addr=eff_addr, mem_we=store_enable, held stable until mem_ready; on mem_ready SHALL pulse load_latch_en (loads only) and go to WRITEBACK.
REQ-025 WRITEBACK SHALL last one cycle, pulse rd_write_en iff rd_out_enable, set pc to jump_target_addr if jump_enable else pc+4, increment instret, go to FETCH.
REQ-026 mem_req, mem_we, instr_latch_en, load_latch_en, rd_write_en SHALL be 0 in every state not listed as driving them.
REQ-027 mem_ready SHALL be ignored when mem_req=0.
REQ-028 Zero-wait latency SHALL be 4 cycles for non-memory instructions and 5 for loads/stores, FETCH to FETCH.
REQ-029 pc+4 and instret+1 SHALL wrap modulo 2^XLEN without flag.
REQ-030 HALT SHALL be absorbing: halted=1, no requests, pc and instret frozen until reset.

Reset
REQ-031 On reset SHALL enter FETCH with pc=RESET_PC, instret=0, halted=0, all strobes 0; mem_req=1 from the first post-reset cycle.
REQ-032 Reset asserted in any state, including mid-MEM with mem_ready pending, SHALL abandon the transaction without write strobe or PC update.

Structure
REQ-033 State enum hart_state_t and RESET_PC default SHALL live in isa_types; opcode_t and XLEN are reused from there.
REQ-034 The FSM SHALL be a single module; no sub-module needed; PC and instret registers SHALL be local.

Verification
REQ-035 Reset, mem_ready=1 -> cycle 1: state FETCH, mem_req=1, mem_addr=0, pc=0.
REQ-036 ADDI, mem_ready always 1, rd_out_enable=1 -> rd_write_en pulse in cycle 4, then pc=4, instret=1.
REQ-037 LW, eff_addr=0x200, mem_ready low 3 cycles in MEM -> mem_req/mem_addr=0x200 held 4 cycles, load_latch_en with mem_ready, rd_write_en next cycle.
REQ-038 SW, store_enable=1 -> MEM with mem_we=1, no rd_write_en; JAL jump_target_addr=0x1A8 -> pc=0x1A8 after WRITEBACK.
REQ-039 OPCODE_UNKNOWN -> halted=1 from cycle after DECODE, mem_req=0 forever, pc unchanged.
REQ-040 Reset during MEM with mem_ready=1 -> next cycle FETCH, pc=RESET_PC, no load_latch_en or rd_write_en pulse.
